// File: rtl/tg_pwrup_seq_if.sv
// Handshake bundle between the reset/config side and the power-up sequencer:
// request inputs, per-step delays, staged enables and status.
interface tg_pwrup_seq_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] dly1;
    logic [CNT_W-1:0] dly2;
    logic [CNT_W-1:0] dly3;
    logic             en1;
    logic             en2;
    logic             en3;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [2:0]       state;

    modport master (
        output start, abort, dly1, dly2, dly3,
        input  en1, en2, en3, busy, done, aborted, state
    );

    modport slave (
        input  start, abort, dly1, dly2, dly3,
        output en1, en2, en3, busy, done, aborted, state
    );
endinterface

// File: rtl/tg_pwrup_seq.sv
// Power-up sequencer: after start, raises en1..en3 one at a time, each after its
// own captured delay; abort unwinds the raised enables highest first.
module tg_pwrup_seq #(
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    tg_pwrup_seq_if.slave      bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT1 = 3'd1,
        S_WAIT2 = 3'd2,
        S_WAIT3 = 3'd3,
        S_DONE  = 3'd4,
        S_PWRDN = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_dly2;
    logic [CNT_W-1:0] w_dly2_nxt;
    logic [CNT_W-1:0] r_dly3;
    logic [CNT_W-1:0] w_dly3_nxt;
    logic             r_en1;
    logic             r_en2;
    logic             r_en3;
    logic             r_busy;
    logic             r_done;
    logic             r_aborted;
    logic             w_en1_nxt;
    logic             w_en2_nxt;
    logic             w_en3_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_aborted_nxt;
    logic             w_cnt_zero;
    logic             w_go;

    assign w_cnt_zero = (r_cnt == {CNT_W{1'b0}});
    // abort beats a simultaneous start in IDLE
    assign w_go       = bus.start & ~bus.abort;

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= {CNT_W{1'b0}};
            r_dly2    <= {CNT_W{1'b0}};
            r_dly3    <= {CNT_W{1'b0}};
            r_en1     <= 1'b0;
            r_en2     <= 1'b0;
            r_en3     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dly2    <= w_dly2_nxt;
            r_dly3    <= w_dly3_nxt;
            r_en1     <= w_en1_nxt;
            r_en2     <= w_en2_nxt;
            r_en3     <= w_en3_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go) w_state_nxt = S_WAIT1;
                else      w_state_nxt = S_IDLE;
            end
            S_WAIT1: begin
                if (bus.abort)       w_state_nxt = S_PWRDN;
                else if (w_cnt_zero) w_state_nxt = S_WAIT2;
                else                 w_state_nxt = S_WAIT1;
            end
            S_WAIT2: begin
                if (bus.abort)       w_state_nxt = S_PWRDN;
                else if (w_cnt_zero) w_state_nxt = S_WAIT3;
                else                 w_state_nxt = S_WAIT2;
            end
            S_WAIT3: begin
                if (bus.abort)       w_state_nxt = S_PWRDN;
                else if (w_cnt_zero) w_state_nxt = S_DONE;
                else                 w_state_nxt = S_WAIT3;
            end
            S_DONE: begin
                if (bus.abort) w_state_nxt = S_PWRDN;
                else           w_state_nxt = S_DONE;
            end
            S_PWRDN: begin
                if (!r_en3 && !r_en2) w_state_nxt = S_IDLE;
                else                  w_state_nxt = S_PWRDN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counter, captured delays and next values of the registered outputs
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_dly2_nxt    = r_dly2;
        w_dly3_nxt    = r_dly3;
        w_en1_nxt     = r_en1;
        w_en2_nxt     = r_en2;
        w_en3_nxt     = r_en3;
        w_aborted_nxt = r_aborted;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_cnt_nxt     = bus.dly1;
                    w_dly2_nxt    = bus.dly2;
                    w_dly3_nxt    = bus.dly3;
                    w_aborted_nxt = 1'b0;
                end else begin
                    w_cnt_nxt     = r_cnt;
                end
            end
            S_WAIT1: begin
                if (bus.abort) begin
                    w_aborted_nxt = 1'b1;
                end else if (w_cnt_zero) begin
                    w_en1_nxt = 1'b1;
                    w_cnt_nxt = r_dly2;
                end else begin
                    w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_WAIT2: begin
                if (bus.abort) begin
                    w_aborted_nxt = 1'b1;
                end else if (w_cnt_zero) begin
                    w_en2_nxt = 1'b1;
                    w_cnt_nxt = r_dly3;
                end else begin
                    w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_WAIT3: begin
                if (bus.abort) begin
                    w_aborted_nxt = 1'b1;
                end else if (w_cnt_zero) begin
                    w_en3_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                if (bus.abort) w_aborted_nxt = 1'b1;
                else           w_aborted_nxt = r_aborted;
            end
            S_PWRDN: begin
                // unwind highest enable first, one per edge
                if (r_en3)      w_en3_nxt = 1'b0;
                else if (r_en2) w_en2_nxt = 1'b0;
                else            w_en1_nxt = 1'b0;
            end
            default: begin
                w_en1_nxt = 1'b0;
                w_en2_nxt = 1'b0;
                w_en3_nxt = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    assign bus.en1     = r_en1;
    assign bus.en2     = r_en2;
    assign bus.en3     = r_en3;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.aborted = r_aborted;
    assign bus.state   = r_state;

endmodule
